// File: rtl/ber_sync.sv
// Self-aligning BER checker: searches the reference-to-receive latency over DEPTH
// candidate delays, then counts bits and errors while the alignment holds.
module ber_sync #(
   parameter  int NB_COUNT = 64,
   parameter  int DEPTH    = 512,
   parameter  int WINDOW   = 1024,
   parameter  int THRESH   = 0,
   localparam int NB_DELAY = $clog2(DEPTH)
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                i_enable,
   input  logic                i_valid,
   input  logic                i_rx,
   input  logic                i_ref,
   output logic                o_lock,
   output logic [NB_DELAY-1:0] o_delay,
   output logic [NB_COUNT-1:0] o_bits,
   output logic [NB_COUNT-1:0] o_errors
);

   localparam int NB_WCNT   = $clog2(WINDOW);
   localparam int NB_WERR   = $clog2(WINDOW + 1);
   localparam int THR_CLAMP = (THRESH > WINDOW) ? WINDOW : THRESH;

   localparam logic [NB_WCNT-1:0]  WCNT_LAST  = NB_WCNT'(WINDOW - 1);
   localparam logic [NB_WERR-1:0]  WERR_MAX   = NB_WERR'(WINDOW);
   localparam logic [NB_WERR:0]    THR_L      = (NB_WERR + 1)'(THR_CLAMP);
   localparam logic [NB_DELAY-1:0] DELAY_LAST = NB_DELAY'(DEPTH - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_SEARCH, ST_LOCK} state_t;

   function automatic logic [NB_COUNT-1:0] sat_count(input logic [NB_COUNT-1:0] v,
                                                    input logic inc);
      if (inc && (v != {NB_COUNT{1'b1}})) return v + NB_COUNT'(1);
      return v;
   endfunction

   function automatic logic [NB_WERR-1:0] sat_werr(input logic [NB_WERR-1:0] v,
                                                   input logic inc);
      if (inc && (v != WERR_MAX)) return v + NB_WERR'(1);
      return v;
   endfunction

   state_t              r_state;
   state_t              w_state_n;
   logic [DEPTH-2:0]    r_hist;
   logic [DEPTH-1:0]    w_taps;
   logic [NB_WCNT-1:0]  r_win_cnt;
   logic [NB_WERR-1:0]  r_win_err;
   logic [NB_WERR:0]    w_err_tot;
   logic [NB_DELAY-1:0] r_delay;
   logic [NB_DELAY-1:0] w_delay_n;
   logic                r_lock;
   logic                w_lock_n;
   logic [NB_COUNT-1:0] r_bits;
   logic [NB_COUNT-1:0] r_errors;
   logic                w_mis;
   logic                w_last;
   logic                w_pass;
   logic                w_win_clr;
   logic                w_win_inc;
   logic                w_start;
   logic                w_acc;

   // Tap 0 is the live reference bit, tap k the reference k strobes ago.
   assign w_taps    = {r_hist, i_ref};
   assign w_mis     = i_rx ^ w_taps[r_delay];
   assign w_last    = i_valid && (r_win_cnt == WCNT_LAST);
   assign w_err_tot = {1'b0, r_win_err} + {{NB_WERR{1'b0}}, w_mis};
   assign w_pass    = (w_err_tot <= THR_L);

   always_ff @(posedge clock) begin
      if (reset)
         r_hist <= '0;
      else if (i_valid)
         r_hist <= w_taps[DEPTH-2:0];
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_delay <= '0;
         r_lock  <= 1'b0;
      end else begin
         r_state <= w_state_n;
         r_delay <= w_delay_n;
         r_lock  <= w_lock_n;
      end
   end

   always_comb begin
      w_state_n = r_state;
      w_delay_n = r_delay;
      w_lock_n  = r_lock;
      w_win_clr = 1'b0;
      w_win_inc = 1'b0;
      w_start   = 1'b0;
      w_acc     = 1'b0;
      if (!i_enable) begin
         w_state_n = ST_IDLE;
         w_lock_n  = 1'b0;
         w_win_clr = 1'b1;
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_state_n = ST_SEARCH;
               w_delay_n = '0;
               w_win_clr = 1'b1;
               w_start   = 1'b1;
            end
            ST_SEARCH: begin
               w_win_inc = i_valid;
               if (w_last) begin
                  w_win_clr = 1'b1;
                  if (w_pass) begin
                     w_state_n = ST_LOCK;
                     w_lock_n  = 1'b1;
                  end else begin
                     w_delay_n = (r_delay == DELAY_LAST) ? '0 : r_delay + NB_DELAY'(1);
                  end
               end
            end
            ST_LOCK: begin
               w_win_inc = i_valid;
               w_acc     = i_valid;
               // The final strobe of a failing window is still counted.
               if (w_last) begin
                  w_win_clr = 1'b1;
                  if (!w_pass) begin
                     w_state_n = ST_SEARCH;
                     w_delay_n = '0;
                     w_lock_n  = 1'b0;
                  end
               end
            end
            default: begin
               w_state_n = ST_IDLE;
               w_lock_n  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset || w_win_clr) begin
         r_win_cnt <= '0;
         r_win_err <= '0;
      end else if (w_win_inc) begin
         r_win_cnt <= r_win_cnt + NB_WCNT'(1);
         r_win_err <= sat_werr(r_win_err, w_mis);
      end
   end

   always_ff @(posedge clock) begin
      if (reset || w_start) begin
         r_bits   <= '0;
         r_errors <= '0;
      end else if (w_acc) begin
         r_bits   <= sat_count(r_bits, 1'b1);
         r_errors <= sat_count(r_errors, w_mis);
      end
   end

   assign o_lock   = r_lock;
   assign o_delay  = r_delay;
   assign o_bits   = r_bits;
   assign o_errors = r_errors;

endmodule

// File: doc/ber_sync.md
# ber_sync

Self-aligning bit-error-rate checker with a parametrised delay search. It compares a received bit stream against a local reference sequence such as the prbs9 output. The block finds the reference-to-receive latency by itself, so the testbench needs no hand-sized delay buffer. Once locked, it counts bits and errors, and it re-acquires alignment automatically when lock is lost. It sits at the receive end of the filter chain, strobed by the same `control` valid pulse as the generator.

## Interface
- `NB_COUNT`, 64: width of `o_bits` and `o_errors`.
- `DEPTH`, 512: number of delay candidates, 0..DEPTH-1 valid strobes; must be ≥ 2.
- `WINDOW`, 1024: valid strobes per evaluation window; must be ≥ DEPTH.
- `THRESH`, 0: maximum window errors still accepted as aligned.
- `NB_DELAY`, derived = $clog2(DEPTH): width of `o_delay`.
- Clocking and reset: reset reset, synchronous, active-high; clock clock.

Ports (name, direction, width, meaning):
- `clock` in 1: clock.
- `reset` in 1: synchronous active-high reset.
- `i_enable` in 1: run/stop. A rising level from IDLE starts a new measurement.
- `i_valid` in 1: bit strobe. `i_rx` and `i_ref` are sampled only when it is high.
- `i_rx` in 1: received bit.
- `i_ref` in 1: reference bit.
- `o_lock` out 1: aligned and counting.
- `o_delay` out NB_DELAY: candidate under test (SEARCH) or locked delay (LOCK).
- `o_bits` out NB_COUNT: bits counted while locked. Saturates at all-ones.
- `o_errors` out NB_COUNT: errors counted while locked. Saturates at all-ones.

## Operation
- **Reference history:** shift register of DEPTH entries, advanced only on `i_valid`. Cleared to 0 by reset only; unaffected by FSM state.
- **Delay d:** compares `i_rx` at strobe n with `i_ref` at strobe n-d. d=0 compares against the same-strobe `i_ref`. Empty history reads 0 and is compared normally.
- **mismatch** = `i_rx` XOR delayed ref(d), evaluated only on `i_valid`.
- **Window counters:**
  - `win_cnt` counts strobes 0..WINDOW-1.
  - `win_err` counts mismatches and saturates at WINDOW.
  - Both are cleared at every window end and on every state entry.
- **FSM states:** IDLE, SEARCH, LOCK.
- **IDLE:**
  - `o_lock`=0; `o_bits` and `o_errors` hold.
  - `i_enable`=1 → SEARCH, d=0, `o_bits`=0, `o_errors`=0.
- **SEARCH:**
  - Accumulate `win_err` for d.
  - Window end with total errors ≤ THRESH → LOCK, `o_delay`=d.
  - Otherwise d=d+1; after DEPTH-1 it wraps to 0. Search continues indefinitely.
- **LOCK:**
  - Each strobe: `o_bits`+1; `o_errors`+mismatch.
  - Window end with total errors > THRESH → SEARCH at d=0, `o_lock`=0.
  - `o_bits` and `o_errors` hold on loss of lock and resume accumulating on relock; they are not cleared.
- **`i_enable`=0** in any state → IDLE on the next edge. Counters hold.
- "Total errors" at a window end includes the mismatch of the final strobe.

## Timing
- **Reset values:** `o_lock`=0, `o_delay`=0, `o_bits`=0, `o_errors`=0. FSM=IDLE, history all 0.
- **Output latency:** all outputs are registered. `o_bits` and `o_errors` reflect strobe n one cycle after the `i_valid` edge.
- **Acquisition:** `o_lock` rises one cycle after the last strobe of the first passing window. Clean acquisition at delay k takes (k+1)·WINDOW strobes from enable.
- **Final strobe of a failing LOCK window:** counted in `o_bits` and `o_errors` before `o_lock` falls, in the same update.
- **`i_valid` with the IDLE→SEARCH transition:** the strobe is not counted, but the history still shifts.
- **`i_valid` ignored:** no counter or state advance while `i_valid`=0. Strobe spacing is arbitrary; back-to-back strobes are allowed.
- **Reset mid-operation:** takes priority over everything. Outputs are 0 one cycle later.

## Test plan
1. **Clean acquisition:**
   - Stimulus: prbs9 seed 'h1AA, valid every 4 clocks, `i_rx` = ref delayed 4 strobes, defaults.
   - Required: `o_lock` rises after 5·1024 strobes with `o_delay`=4. After 2000 further strobes, `o_bits`=2000 and `o_errors`=0.
2. **No-lock wraparound:**
   - Stimulus: DEPTH=8, WINDOW=16, `i_rx` = inverted ref.
   - Required: `o_lock` stays 0. `o_delay` steps 0..7 then wraps to 0, one step per 16 strobes.
3. **Error injection:**
   - Stimulus: single `i_rx` flip while locked.
   - With THRESH=1: `o_lock` stays 1, `o_errors`=1.
   - With THRESH=0: `o_lock` falls at that window end, relocks at `o_delay`=4 after 5 windows, and `o_errors` stays 1 across the relock.
4. **Enable toggle:**
   - Stimulus: `i_enable`=0 mid-LOCK.
   - Required: `o_lock`=0 next cycle, counters hold.
   - Stimulus: `i_enable`=1 again.
   - Required: `o_bits`=`o_errors`=0 on the next cycle, search restarts at d=0.
5. **Reset mid-SEARCH:** assert reset.
   - Required: all outputs are 0 one cycle later, and there is no lock until enabled again.
6. **Saturation:**
   - Stimulus: NB_COUNT=4, clean lock, 20 strobes.
   - Required: `o_bits` holds 15 and does not wrap.
